// File: rtl/char_mem_write_ctrl_if.sv
// char_mem_write_ctrl_if: host-side glyph load handshake (valid/ready word transfer plus abort)
interface char_mem_write_ctrl_if #(parameter int W = 15) ();
    logic         load_valid;
    logic         load_ready;
    logic [W-1:0] load_data;
    logic         abort;
    modport master (output load_valid, load_data, abort, input load_ready);
    modport slave (input load_valid, load_data, abort, output load_ready);
endinterface

// File: rtl/char_mem_write_ctrl.sv
// char_mem_write_ctrl: serialises a host glyph word into per-cell writes on a port shared with the VGA reader
module char_mem_write_ctrl #(
    parameter int COLS   = 3,
    parameter int ROWS   = 5,
    parameter int X_BASE = 1
) (
    input  logic                        i_clock,
    input  logic                        i_rst_n,
    char_mem_write_ctrl_if.slave        bus,
    input  logic                        i_rd_active,
    input  logic [1:0]                  i_rd_x,
    input  logic [2:0]                  i_rd_y,
    output logic                        o_mem_write,
    output logic [1:0]                  o_mem_x,
    output logic [2:0]                  o_mem_y,
    output logic                        o_mem_data,
    output logic                        o_busy,
    output logic                        o_done,
    output logic [7:0]                  o_stall_count
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WRITE = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;
    localparam int IW = $clog2(ROWS * COLS);

    logic [1:0]           r_state;
    logic [2:0]           r_row;
    logic [1:0]           r_col;
    logic [ROWS*COLS-1:0] r_shadow;
    logic [7:0]           r_stall;
    logic                 w_wr;
    logic                 w_col_end;
    logic                 w_last;
    logic [IW-1:0]        w_idx;

    assign w_wr      = r_state == WRITE && !i_rd_active;
    assign w_col_end = r_col == 2'(COLS - 1);
    assign w_last    = w_col_end && r_row == 3'(ROWS - 1);
    assign w_idx     = IW'(r_row * COLS + r_col);

    // The reader owns the address lines whenever it is active, regardless of state
    assign o_mem_write    = w_wr && !bus.abort;
    assign o_mem_x        = w_wr ? 2'(X_BASE) + r_col : i_rd_x;
    assign o_mem_y        = w_wr ? r_row : i_rd_y;
    assign o_mem_data     = w_wr ? r_shadow[w_idx] : 1'b0;
    assign bus.load_ready = r_state == IDLE;
    assign o_busy         = r_state != IDLE;
    assign o_done         = r_state == DONE;
    assign o_stall_count  = r_stall;

    always_ff @(posedge i_clock or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= IDLE;
            r_row    <= 3'd0;
            r_col    <= 2'd0;
            r_shadow <= '0;
            r_stall  <= 8'd0;
        end else begin
            case (r_state)
                IDLE: if (bus.load_valid) begin
                    r_shadow <= bus.load_data;
                    r_row    <= 3'd0;
                    r_col    <= 2'd0;
                    r_stall  <= 8'd0;
                    r_state  <= WRITE;
                end
                WRITE: if (bus.abort) begin
                    r_state <= IDLE;
                end else if (i_rd_active) begin
                    r_stall <= r_stall == 8'hFF ? r_stall : r_stall + 8'd1;
                end else begin
                    r_col   <= w_col_end ? 2'd0 : r_col + 2'd1;
                    r_row   <= r_row + 3'(w_col_end);
                    r_state <= w_last ? DONE : WRITE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_char_mem_write_ctrl.sv
// tb_char_mem_write_ctrl: scoreboard bench; expected cell writes are queued at load time and popped per DUT write
module tb_char_mem_write_ctrl;
    logic       clk;
    logic       rst_n;
    logic       rd_active;
    logic [1:0] rd_x;
    logic [2:0] rd_y;
    logic       mem_write;
    logic [1:0] mem_x;
    logic [2:0] mem_y;
    logic       mem_data;
    logic       busy;
    logic       done;
    logic [7:0] stall_count;

    char_mem_write_ctrl_if #(.W(15)) bus ();

    char_mem_write_ctrl dut (
        .i_clock      (clk),
        .i_rst_n      (rst_n),
        .bus          (bus),
        .i_rd_active  (rd_active),
        .i_rd_x       (rd_x),
        .i_rd_y       (rd_y),
        .o_mem_write  (mem_write),
        .o_mem_x      (mem_x),
        .o_mem_y      (mem_y),
        .o_mem_data   (mem_data),
        .o_busy       (busy),
        .o_done       (done),
        .o_stall_count(stall_count)
    );

    int         n_vec = 0;
    int         n_err = 0;
    int         n_done = 0;
    int         n_wr = 0;
    int         exp_done = 0;
    logic [5:0] sb[$];

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && mem_write) begin
            n_wr++;
            if (sb.size() == 0) check("unexp_wr", 1, 0);
            else check("cell_ydx", {26'd0, mem_y, mem_x, mem_data}, {26'd0, sb.pop_front()});
        end
        if (rst_n && done) n_done++;
    end

    task automatic do_load(input logic [14:0] d, input bit hold, input int st_lo, input int st_hi, input int stop_c);
        int nst;
        int c;
        bit fin;
        nst = (st_hi >= st_lo) ? st_hi - st_lo + 1 : 0;
        bus.load_data  = d;
        bus.load_valid = 1'b1;
        @(negedge clk);
        check("accept_rdy", bus.load_ready, 1);
        @(posedge clk); #1;
        if (!hold) bus.load_valid = 1'b0;
        for (int k = 0; k < 15; k++) sb.push_back({3'(k / 3), 2'(1 + k % 3), d[k]});
        fin = 0;
        c = 0;
        while (!fin) begin
            c++;
            rd_active = c >= st_lo && c <= st_hi;
            rd_x = 2'($urandom);
            rd_y = 3'($urandom);
            bus.load_data = 15'($urandom);
            @(negedge clk);
            if (rd_active) begin
                check("stall_wr", mem_write, 0);
                check("stall_x", mem_x, rd_x);
                check("stall_y", mem_y, rd_y);
            end
            if (done) begin
                check("done_cyc", c, 16 + nst);
                check("stall_cnt", stall_count, nst > 255 ? 255 : nst);
                fin = 1;
            end else if (c == stop_c) begin
                check("busy_mid", busy, 1);
                fin = 1;
            end else if (c >= 400) begin
                check("timeout", c, 16 + nst);
                fin = 1;
            end
            @(posedge clk); #1;
        end
        rd_active = 1'b0;
        if (stop_c == 0) exp_done++;
    endtask

    initial begin
        int d0;
        int w0;
        clk = 0;
        rst_n = 0;
        rd_active = 0;
        rd_x = 0;
        rd_y = 0;
        bus.load_valid = 0;
        bus.load_data = 0;
        bus.abort = 0;
        #12;
        check("rst_wr", mem_write, 0);
        check("rst_rdy", bus.load_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_stall", stall_count, 0);
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;
        do_load(15'h5A5A, 0, 1, 0, 0);
        check("t1_rdy", bus.load_ready, 1);
        do_load(15'h5A5A, 0, 3, 6, 0);
        do_load(15'h1234, 1, 1, 300, 0);
        check("t3_rdy", bus.load_ready, 1);
        bus.load_valid = 0;
        do_load(15'h2B6D, 0, 1, 0, 6);
        bus.abort = 1;
        @(negedge clk);
        check("abort_wr", mem_write, 0);
        @(posedge clk); #1;
        bus.abort = 0;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_rdy", bus.load_ready, 1);
        check("abort_done", done, 0);
        check("abort_left", sb.size(), 9);
        sb.delete();
        @(posedge clk); #1;
        do_load(15'h4321, 0, 1, 0, 0);
        do_load(15'h6F0F, 0, 2, 3, 5);
        check("t5_pre_wr", mem_write, 1);
        check("t5_pre_stall", stall_count, 2);
        #2 rst_n = 0;
        #1;
        check("t5_rst_wr", mem_write, 0);
        check("t5_rst_busy", busy, 0);
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1;
        @(negedge clk);
        check("t5_rdy", bus.load_ready, 1);
        check("t5_stall", stall_count, 0);
        @(posedge clk); #1;
        d0 = n_done;
        w0 = n_wr;
        do_load(15'h7FFF, 1, 1, 0, 0);
        check("t6_rdy", bus.load_ready, 1);
        do_load(15'h0001, 0, 1, 0, 0);
        check("t6_dones", n_done - d0, 2);
        check("t6_writes", n_wr - w0, 30);
        check("sb_empty", sb.size(), 0);
        check("done_total", n_done, exp_done);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
